// File: rtl/instr_sequencer.sv
// Program-memory instruction sequencer: issues up to DEPTH stored words in order
// over a valid/ready handshake and flags completion.
module instr_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              halt,
  output logic [WIDTH-1:0]  instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W:0]     len_q;
  logic [WIDTH-1:0]    instr_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   pc_out_q;
  logic                busy_q;
  logic                done_q;

  logic [WIDTH-1:0]    mem [DEPTH];

  logic [ADDR_W:0]     len_d;
  logic                mem_we;
  logic                last_word;
  logic                handshake;

  always_comb begin
    len_d     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    // halt outranks every other input, including a program load
    mem_we    = load_en && !halt && ((state_q == IDLE) || (state_q == DONE));
    last_word = ({1'b0, pc_q} == (len_q - LEN_ONE));
    handshake = valid_q && instr_ready;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (halt) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q <= len_d;
            pc_q  <= '0;
            if (len_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= FETCH;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          instr_q  <= mem[pc_q];
          pc_out_q <= pc_q;
          valid_q  <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (last_word) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              pc_q    <= pc_q + PC_ONE;
              state_q <= FETCH;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations and random programs.
module tb_instr_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          halt = 1'b0;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_mem [16];
  bit          m_run = 0;
  bit          m_done = 0;
  int          m_idx = 0;
  int          m_wait = 0;
  int          m_len = 0;

  int          log_pc[$];
  logic [31:0] log_word[$];

  instr_sequencer #(.DEPTH(16), .ADDR_W(AW), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .halt(halt),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: compare outputs with the model, then advance the model using
  // the inputs the DUT will sample on the coming rising edge.
  initial begin
    bit exp_valid;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_run = 0; m_done = 0; m_idx = 0; m_wait = 0;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_instr", instr_out, 0);
      end else begin
        exp_valid = m_run && (m_wait >= 1);
        chk("valid", 32'(instr_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        if (exp_valid) begin
          chk("pc_out", 32'(pc_out), 32'(m_idx));
          chk("instr_out", instr_out, m_mem[m_idx]);
        end
        if (instr_valid && instr_ready && !halt) begin
          log_pc.push_back(int'(pc_out));
          log_word.push_back(instr_out);
        end
        if (halt) begin
          m_run = 0; m_done = 0; m_idx = 0; m_wait = 0;
        end else if (!m_run) begin
          if (load_en) m_mem[load_addr] = load_data;
          if (start) begin
            m_len  = (int'(prog_len) > 16) ? 16 : int'(prog_len);
            m_idx  = 0;
            m_wait = 0;
            if (m_len == 0) m_done = 1;
            else begin m_run = 1; m_done = 0; end
          end
        end else if (exp_valid && instr_ready) begin
          m_idx++;
          m_wait = 0;
          if (m_idx == m_len) begin m_run = 0; m_done = 1; end
        end else begin
          m_wait++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a[AW-1:0]; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_prog(input int len);
    log_pc.delete(); log_word.delete();
    prog_len = len[AW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_edges, input bit rnd);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      if (rnd) instr_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk({nm, "_done"}, 32'(done), 1);
    if (exp_edges >= 0) chk({nm, "_edges"}, 32'(n), 32'(exp_edges));
    instr_ready = 1'b1;
  endtask

  task automatic wait_word(input string nm, input int idx);
    int n = 0;
    while (!(instr_valid === 1'b1 && int'(pc_out) == idx) && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_word_seen"}, 32'(n < 50), 1);
  endtask

  task automatic check_prog3(input string nm);
    chk({nm, "_count"}, 32'(log_word.size()), 3);
    if (log_word.size() == 3) begin
      chk({nm, "_w0"}, log_word[0], 32'h00221820);
      chk({nm, "_w1"}, log_word[1], 32'h00432022);
      chk({nm, "_w2"}, log_word[2], 32'h00642824);
      chk({nm, "_pc2"}, 32'(log_pc[2]), 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("reset_valid", 32'(instr_valid), 0);
    chk("reset_pc", 32'(pc_out), 0);
    rst = 1'b0;

    load(0, 32'h00221820);
    load(1, 32'h00432022);
    load(2, 32'h00642824);
    for (int i = 3; i < 16; i++) load(i, 32'h10000000 + i);

    // basic three-word program, ready always high
    instr_ready = 1'b1;
    start_prog(3);
    wait_done("prog3", 6, 0);
    check_prog3("prog3");

    // backpressure on word 1
    start_prog(3);
    wait_word("bp", 1);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_instr", instr_out, 32'h00432022);
      chk("bp_hold_pc", 32'(pc_out), 1);
    end
    instr_ready = 1'b1;
    wait_done("bp", -1, 0);
    check_prog3("bp");

    // zero-length program
    start_prog(0);
    wait_done("len0", 0, 0);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_words", 32'(log_word.size()), 0);

    // over-long program clamps to DEPTH
    start_prog(17);
    wait_done("len17", 32, 0);
    chk("len17_count", 32'(log_word.size()), 16);
    if (log_word.size() == 16) begin
      chk("len17_last_pc", 32'(log_pc[15]), 15);
      chk("len17_last_word", log_word[15], 32'h1000000f);
    end

    // halt during ISSUE of word 1 together with a handshake
    start_prog(3);
    wait_word("halt", 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_valid", 32'(instr_valid), 0);
    chk("halt_done", 32'(done), 0);
    chk("halt_pc", 32'(pc_out), 0);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_issued", 32'(log_word.size()), 1);
    start_prog(3);
    wait_done("after_halt", 6, 0);
    check_prog3("after_halt");

    // asynchronous reset between edges
    start_prog(3);
    wait_word("arst", 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    start_prog(3);
    wait_done("after_arst", 6, 0);
    check_prog3("after_arst");

    // load during ISSUE is ignored
    start_prog(3);
    wait_word("prot", 0);
    load(0, 32'hdeadbeef);
    wait_done("prot", -1, 0);
    check_prog3("prot");
    start_prog(3);
    wait_done("prot_rerun", 6, 0);
    check_prog3("prot_rerun");

    // reload in DONE, then single-word restart
    load(0, 32'h00a53020);
    start_prog(1);
    wait_done("reload", 2, 0);
    chk("reload_count", 32'(log_word.size()), 1);
    if (log_word.size() == 1) chk("reload_w0", log_word[0], 32'h00a53020);

    // load and start on the same edge
    log_pc.delete(); log_word.delete();
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'h00a63820;
    prog_len = 5'd2; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    wait_done("ldstart", 4, 0);
    chk("ldstart_count", 32'(log_word.size()), 2);
    if (log_word.size() == 2) chk("ldstart_w1", log_word[1], 32'h00a63820);

    // random programs with random backpressure
    for (int it = 0; it < 20; it++) begin
      load($urandom_range(0, 15), $urandom);
      load($urandom_range(0, 15), $urandom);
      start_prog($urandom_range(0, 17));
      wait_done("rand", -1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer that sits directly upstream of the register-file/ALU datapath. It holds a small program memory of 32-bit R-type instruction words and issues them in order over a valid/ready handshake, one word per accepted transfer. It replaces bench-driven instruction stimulus with a clocked, resettable program source, and reports completion.

## Interface

- DEPTH, 16: number of 32-bit program words.
- ADDR_W, 4: program address width; DEPTH = 2**ADDR_W.
- WIDTH, 32: instruction word width.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- load_en  in  1  program-memory write strobe.
- load_addr  in  ADDR_W  write address.
- load_data  in  WIDTH  write data.
- start  in  1  begin issuing the program from address 0.
- prog_len  in  ADDR_W+1  number of words to issue; latched on start.
- halt  in  1  synchronous abort to IDLE.
- instr_out  out  WIDTH  current instruction word.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  downstream accepts instr_out.
- pc_out  out  ADDR_W  address of the word in instr_out.
- busy  out  1  state is FETCH or ISSUE.
- done  out  1  program fully issued.

## Operation

- States: IDLE, FETCH, ISSUE, DONE; state register encoded, all outputs registered.
- Memory: DEPTH x WIDTH, not reset. Write on load_en at the clock edge only in IDLE or DONE; load_en in FETCH/ISSUE is ignored.
- IDLE: on start, latch len = min(prog_len, DEPTH), pc <= 0.
  - If len == 0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: instr_out <= mem[pc], pc_out <= pc, instr_valid <= 1, go to ISSUE. Lasts exactly one cycle.
- ISSUE: instr_valid = 1. instr_out and pc_out are held stable until instr_ready is sampled high.
  - On handshake with pc == len-1: instr_valid <= 0, done <= 1, go to DONE.
  - On handshake otherwise: instr_valid <= 0, pc <= pc+1, go to FETCH.
- DONE: done = 1 and stays high. start behaves as in IDLE (clears done, restarts from address 0).
- halt has priority over every other input in every state. At the next edge: go to IDLE, instr_valid <= 0, done <= 0, pc <= 0. Memory contents are preserved.
- start in FETCH or ISSUE is ignored.
- pc wraps only through restart; pc never exceeds len-1.
- busy = (state == FETCH) or (state == ISSUE).

## Timing

- Reset (async assert): state IDLE; instr_out = 0; instr_valid = 0; pc_out = 0; busy = 0; done = 0.
- Reset is released synchronously to clk by the system; the first active edge after release is the first sampled edge.
- Latency:
  - start sampled at edge E0; FETCH during the cycle after E0.
  - instr_valid rises after E1.
  - The first word is available 2 edges after start.
- Throughput: one word per 2 cycles with instr_ready held high. An N-word program completes in 2N+1 edges from start, and done rises after edge 2N.
- Backpressure: instr_ready low holds ISSUE indefinitely with no change to instr_out or pc_out.
- instr_ready while instr_valid = 0 has no effect.
- Mid-operation reset: outputs go to their reset values immediately. Memory is undefined-unchanged (not cleared).
- Simultaneous events:
  - halt with a handshake: halt wins; the word counts as not issued and done stays 0.
  - load_en with start in IDLE: the write and the latch both occur; the written word is visible to the FETCH that follows.

## Test plan

- Reset then load: load mem[0..2] = 32'h00221820, 32'h00432022, 32'h00642824; start with prog_len = 3 and instr_ready = 1. Expect the three words in order with pc_out 0, 1, 2, valid for one cycle each, and done = 1 after edge 6.
- Backpressure: same program, instr_ready = 0 for 5 cycles during word 1. Expect instr_out = 32'h00432022 and pc_out = 1 held for all 5 cycles, then normal completion with no duplicated or skipped word.
- Boundaries:
  - prog_len = 0: done = 1 one edge after start, and instr_valid never rises.
  - prog_len = 17 with DEPTH = 16: exactly 16 words issued, the last with pc_out = 15.
- Halt mid-run: assert halt in ISSUE of word 1 with instr_ready = 1 on the same edge. Expect IDLE, instr_valid = 0, done = 0, pc_out = 0. A later start reissues from word 0.
- Async reset mid-ISSUE: assert rst between edges. Expect instr_valid = 0 and busy = 0 immediately without a clock edge. A restart after release reissues the unchanged memory contents.
- Load protection and restart: pulse load_en with load_addr = 0 during ISSUE and check mem[0] is unchanged on the rerun. In DONE, load new mem[0] and start with prog_len = 1. Expect the new word issued and done re-asserted.
